// File: rtl/fdiv_share_pkg.sv
// Shared types and constants for the fraction-divider sharing controller.
package fdiv_share_pkg;

  localparam int DIV_W       = 32;
  localparam int TAG_W_DEF   = 4;
  localparam int TIMEOUT_DEF = 15;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  function automatic int wd_width(input int timeout);
    return $clog2(timeout + 1);
  endfunction

  localparam int WD_W_DEF = wd_width(TIMEOUT_DEF);

endpackage

// File: rtl/fdiv_share_ctrl_if.sv
// Request, response and divider-side signals of the divider sharing controller.
interface fdiv_share_ctrl_if
  import fdiv_share_pkg::*;
#(
  parameter int TAG_W = TAG_W_DEF
);

  logic             req0_valid;
  logic             req0_ready;
  logic [DIV_W-1:0] req0_a;
  logic [DIV_W-1:0] req0_b;
  logic [TAG_W-1:0] req0_tag;
  logic             req1_valid;
  logic             req1_ready;
  logic [DIV_W-1:0] req1_a;
  logic [DIV_W-1:0] req1_b;
  logic [TAG_W-1:0] req1_tag;

  logic             rsp0_valid;
  logic             rsp0_ready;
  logic [DIV_W-1:0] rsp0_q;
  logic [TAG_W-1:0] rsp0_tag;
  logic             rsp0_err;
  logic             rsp1_valid;
  logic             rsp1_ready;
  logic [DIV_W-1:0] rsp1_q;
  logic [TAG_W-1:0] rsp1_tag;
  logic             rsp1_err;

  logic             div_start;
  logic [DIV_W-1:0] div_a;
  logic [DIV_W-1:0] div_b;
  logic             div_busy;
  logic             div_ready;
  logic [DIV_W-1:0] div_q;

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_tag,
    input  req1_valid, req1_a, req1_b, req1_tag,
    output req0_ready, req1_ready,
    output rsp0_valid, rsp0_q, rsp0_tag, rsp0_err,
    output rsp1_valid, rsp1_q, rsp1_tag, rsp1_err,
    input  rsp0_ready, rsp1_ready,
    output div_start, div_a, div_b,
    input  div_busy, div_ready, div_q
  );

  modport master (
    output req0_valid, req0_a, req0_b, req0_tag,
    output req1_valid, req1_a, req1_b, req1_tag,
    input  req0_ready, req1_ready,
    input  rsp0_valid, rsp0_q, rsp0_tag, rsp0_err,
    input  rsp1_valid, rsp1_q, rsp1_tag, rsp1_err,
    output rsp0_ready, rsp1_ready,
    input  div_start, div_a, div_b,
    output div_busy, div_ready, div_q
  );

endinterface

// File: rtl/fdiv_share_ctrl_rr_arb2.sv
// Two-way round-robin grant: with both requesting, the one not granted last wins.
module rr_arb2 (
  input  logic [1:0] valid,
  input  logic       last_grant,
  output logic [1:0] grant
);

  // one-hot grant from the request pair and the previous winner
  always_comb begin
    grant = 2'b00;
    case (valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last_grant ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/fdiv_share_ctrl.sv
// Shares one iterative fraction divider between two requesters, one operation
// in flight, with divisor-normalization check and a ready watchdog.
module fdiv_share_ctrl
  import fdiv_share_pkg::*;
#(
  parameter int TAG_W   = TAG_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input logic              clock,
  input logic              reset,
  fdiv_share_ctrl_if.slave bus
);

  localparam int WD_W = wd_width(TIMEOUT);

  state_e           state_r, state_s;
  logic [DIV_W-1:0] a_r, b_r, q_r;
  logic [TAG_W-1:0] tag_r;
  logic             err_r, owner_r, last_grant_r;
  logic [WD_W-1:0]  wd_r;
  logic [1:0]       grant_s, acc_s;
  logic [DIV_W-1:0] sel_a_s, sel_b_s;
  logic [TAG_W-1:0] sel_tag_s;
  logic             rsp_hs_s, wd_expired_s;

  rr_arb2 u_arb (
    .valid      ({bus.req1_valid, bus.req0_valid}),
    .last_grant (last_grant_r),
    .grant      (grant_s)
  );

  // a busy divider here is a stale op left behind by a timeout, so hold off grants
  always_comb begin
    acc_s = 2'b00;
    if (state_r == ST_IDLE && !bus.div_busy && !reset) begin
      acc_s = grant_s;
    end else begin
      acc_s = 2'b00;
    end
  end

  assign sel_a_s      = acc_s[1] ? bus.req1_a   : bus.req0_a;
  assign sel_b_s      = acc_s[1] ? bus.req1_b   : bus.req0_b;
  assign sel_tag_s    = acc_s[1] ? bus.req1_tag : bus.req0_tag;
  assign rsp_hs_s     = owner_r ? bus.rsp1_ready : bus.rsp0_ready;
  assign wd_expired_s = (wd_r == WD_W'(TIMEOUT));

  assign bus.req0_ready = acc_s[0];
  assign bus.req1_ready = acc_s[1];
  assign bus.div_start  = (state_r == ST_START);
  assign bus.div_a      = a_r;
  assign bus.div_b      = b_r;
  assign bus.rsp0_valid = (state_r == ST_RESP) && !owner_r;
  assign bus.rsp1_valid = (state_r == ST_RESP) && owner_r;
  assign bus.rsp0_q     = q_r;
  assign bus.rsp1_q     = q_r;
  assign bus.rsp0_tag   = tag_r;
  assign bus.rsp1_tag   = tag_r;
  assign bus.rsp0_err   = err_r;
  assign bus.rsp1_err   = err_r;

  // state register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_r <= ST_IDLE;
    else       state_r <= state_s;
  end

  // next-state: unnormalized divisors skip the divider; ready beats the watchdog
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (acc_s != 2'b00) state_s = sel_b_s[DIV_W-1] ? ST_START : ST_RESP;
        else                state_s = ST_IDLE;
      end
      ST_START: state_s = ST_WAIT;
      ST_WAIT: begin
        if (bus.div_ready || wd_expired_s) state_s = ST_RESP;
        else                               state_s = ST_WAIT;
      end
      ST_RESP: begin
        if (rsp_hs_s) state_s = ST_IDLE;
        else          state_s = ST_RESP;
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // operand, result, owner and watchdog registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      a_r          <= {DIV_W{1'b0}};
      b_r          <= {DIV_W{1'b0}};
      q_r          <= {DIV_W{1'b0}};
      tag_r        <= {TAG_W{1'b0}};
      err_r        <= 1'b0;
      owner_r      <= 1'b0;
      last_grant_r <= 1'b1;
      wd_r         <= {WD_W{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (acc_s != 2'b00) begin
            a_r     <= sel_a_s;
            b_r     <= sel_b_s;
            tag_r   <= sel_tag_s;
            owner_r <= acc_s[1];
            q_r     <= {DIV_W{1'b0}};
            err_r   <= ~sel_b_s[DIV_W-1];
          end
        end
        ST_START: wd_r <= {WD_W{1'b0}};
        ST_WAIT: begin
          if (bus.div_ready) begin
            q_r   <= bus.div_q;
            err_r <= 1'b0;
          end else if (wd_expired_s) begin
            q_r   <= {DIV_W{1'b0}};
            err_r <= 1'b1;
          end else begin
            wd_r <= wd_r + WD_W'(1);
          end
        end
        ST_RESP: begin
          if (rsp_hs_s) last_grant_r <= owner_r;
        end
        default: wd_r <= {WD_W{1'b0}};
      endcase
    end
  end

endmodule

// File: tb/tb_fdiv_share_ctrl.sv
// Scoreboard bench for fdiv_share_ctrl with a behavioural divider stub.
module tb_fdiv_share_ctrl;
  import fdiv_share_pkg::*;

  localparam int TIMEOUT = 15;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  fdiv_share_ctrl_if #(.TAG_W(4)) bus ();

  fdiv_share_ctrl #(.TAG_W(4), .TIMEOUT(TIMEOUT)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    int          owner;
    logic [31:0] q;
    logic [3:0]  tag;
    logic        err;
    int          cyc;
  } exp_t;

  int   chk = 0;
  int   errs = 0;
  int   cyc = 0;
  exp_t sb[$];
  int   grant_log[$];
  bit   log_on = 1'b0;
  bit   m_op = 1'b0, m_last = 1'b1, m_seen = 1'b0, m_start_pend = 1'b0;
  int   m_start_cyc = 0;
  logic [31:0] m_a = 32'd0, m_b = 32'd0;
  bit   hang = 1'b0, spur = 1'b0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    chk++;
    if (act !== expv) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Fraction quotient: .1xxx / .1xxx scaled to x.xxx (31 fraction bits)
  function automatic logic [31:0] ref_div(input logic [31:0] a, input logic [31:0] b);
    logic [63:0] num;
    num = {1'b0, a, 31'd0};
    return 32'(num / {32'd0, b});
  endfunction

  // Divider stub: ready pulse four cycles after start, or hangs busy when told to
  logic        st_busy, st_ready;
  logic [31:0] st_q;
  int          st_cnt, hang_cnt;
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      st_busy <= 1'b0; st_ready <= 1'b0; st_q <= 32'd0; st_cnt <= 0; hang_cnt <= 0;
    end else begin
      st_ready <= 1'b0;
      if (bus.div_start) begin
        st_busy  <= 1'b1;
        st_cnt   <= hang ? 0 : 3;
        hang_cnt <= hang ? TIMEOUT + 8 : 0;
      end else begin
        if (st_cnt > 1) st_cnt <= st_cnt - 1;
        if (st_cnt == 1) begin
          st_cnt <= 0; st_ready <= 1'b1; st_busy <= 1'b0;
          st_q   <= ref_div(bus.div_a, bus.div_b);
        end
        if (hang_cnt > 1) hang_cnt <= hang_cnt - 1;
        if (hang_cnt == 1) begin hang_cnt <= 0; st_busy <= 1'b0; end
      end
    end
  end
  assign bus.div_busy  = st_busy;
  assign bus.div_ready = st_ready | spur;
  assign bus.div_q     = st_q;

  // Monitor: predicts grants, pushes expectations on acceptance, checks responses
  always @(negedge clock) begin
    bit v0, v1, r0, r1, pg0, pg1, rv0, rv1, hs, err;
    int p;
    exp_t e;
    logic [31:0] a, b, q;
    logic [3:0] tag;
    if (reset) begin
      sb.delete(); m_op = 1'b0; m_last = 1'b1; m_seen = 1'b0; m_start_pend = 1'b0;
    end else begin
      v0 = bus.req0_valid; v1 = bus.req1_valid; r0 = bus.req0_ready; r1 = bus.req1_ready;
      pg0 = 1'b0; pg1 = 1'b0;
      if (!m_op && !bus.div_busy) begin
        if (v0 && v1) begin pg0 = m_last; pg1 = !m_last; end
        else begin pg0 = v0; pg1 = v1; end
      end
      check("req0_ready", 64'(r0), 64'(pg0));
      check("req1_ready", 64'(r1), 64'(pg1));
      if (m_op) begin
        check("div_a_hold", 64'(bus.div_a), 64'(m_a));
        check("div_b_hold", 64'(bus.div_b), 64'(m_b));
      end
      if (bus.div_start) begin
        check("div_start_expected", 64'(m_start_pend), 64'(1));
        if (m_start_pend) check("div_start_cycle", 64'(cyc), 64'(m_start_cyc));
        m_start_pend = 1'b0;
      end else if (m_start_pend && cyc > m_start_cyc) begin
        check("div_start_seen", 64'(bus.div_start), 64'(1));
        m_start_pend = 1'b0;
      end
      rv0 = bus.rsp0_valid; rv1 = bus.rsp1_valid;
      if (rv0 || rv1) begin
        check("rsp_onehot", 64'(rv0 & rv1), 64'(0));
        if (sb.size() == 0) begin
          check("rsp_unexpected", 64'(rv0 | rv1), 64'(0));
        end else begin
          e = sb[0];
          check("rsp_owner", 64'(rv1), 64'(e.owner));
          if (e.owner == 0) begin q = bus.rsp0_q; tag = bus.rsp0_tag; err = bus.rsp0_err; hs = bus.rsp0_ready; end
          else begin q = bus.rsp1_q; tag = bus.rsp1_tag; err = bus.rsp1_err; hs = bus.rsp1_ready; end
          check("rsp_q", 64'(q), 64'(e.q));
          check("rsp_tag", 64'(tag), 64'(e.tag));
          check("rsp_err", 64'(err), 64'(e.err));
          if (!m_seen) begin check("rsp_latency", 64'(cyc), 64'(e.cyc)); m_seen = 1'b1; end
          if (hs) begin
            void'(sb.pop_front());
            m_op = 1'b0; m_last = (e.owner != 0); m_seen = 1'b0;
          end
        end
      end else if (sb.size() != 0 && !m_seen && cyc > sb[0].cyc) begin
        check("rsp_valid_in_time", 64'(rv0 | rv1), 64'(1));
        m_seen = 1'b1;
      end
      if ((v0 && r0) || (v1 && r1)) begin
        p   = (v1 && r1 && !(v0 && r0)) ? 1 : 0;
        a   = p ? bus.req1_a : bus.req0_a;
        b   = p ? bus.req1_b : bus.req0_b;
        tag = p ? bus.req1_tag : bus.req0_tag;
        e.owner = p; e.tag = tag;
        if (!b[31]) begin
          e.q = 32'd0; e.err = 1'b1; e.cyc = cyc + 1;
        end else begin
          m_start_pend = 1'b1; m_start_cyc = cyc + 1;
          if (hang) begin e.q = 32'd0; e.err = 1'b1; e.cyc = cyc + TIMEOUT + 3; end
          else begin e.q = ref_div(a, b); e.err = 1'b0; e.cyc = cyc + 6; end
        end
        sb.push_back(e);
        m_op = 1'b1; m_a = a; m_b = b; m_seen = 1'b0;
        if (log_on) grant_log.push_back(p);
      end
    end
  end

  task automatic set_req(input int p, input logic [31:0] a, input logic [31:0] b, input logic [3:0] tag);
    if (p == 0) begin bus.req0_valid = 1'b1; bus.req0_a = a; bus.req0_b = b; bus.req0_tag = tag; end
    else begin bus.req1_valid = 1'b1; bus.req1_a = a; bus.req1_b = b; bus.req1_tag = tag; end
  endtask

  task automatic rand_req(input int p);
    logic [31:0] a, b;
    a = {1'b1, 31'($urandom)};
    b = {($urandom_range(0, 4) != 0), 31'($urandom)};
    set_req(p, a, b, 4'($urandom));
  endtask

  task automatic wait_accept(input int p);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 80 && !got; i++) begin
      @(negedge clock);
      got = (p == 0) ? (bus.req0_valid && bus.req0_ready) : (bus.req1_valid && bus.req1_ready);
      @(posedge clock); #1;
    end
    check($sformatf("accept_req%0d", p), 64'(got), 64'(1));
    if (p == 0) bus.req0_valid = 1'b0;
    else        bus.req1_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((sb.size() != 0 || m_op) && n < 200) begin @(posedge clock); #1; n++; end
    check("drain", 64'(sb.size()), 64'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout");
    $fatal(1, "bench did not finish");
  end

  initial begin
    bit a0, a1;
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    bus.req0_a = 32'd0; bus.req0_b = 32'd0; bus.req0_tag = 4'd0;
    bus.req1_a = 32'd0; bus.req1_b = 32'd0; bus.req1_tag = 4'd0;
    bus.rsp0_ready = 1'b1; bus.rsp1_ready = 1'b1;

    // Both valid at reset release: grants must alternate 0,1,0,1
    set_req(0, 32'hA000_0000, 32'h8000_0000, 4'd1);
    set_req(1, 32'h8000_0000, 32'hC000_0000, 4'd2);
    repeat (3) @(posedge clock);
    #1;
    check("reset_no_rsp", 64'({bus.rsp0_valid, bus.rsp1_valid, bus.div_start}), 64'(0));
    reset = 1'b0;
    log_on = 1'b1;
    for (int i = 0; i < 200 && grant_log.size() < 4; i++) begin @(posedge clock); #1; end
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    log_on = 1'b0;
    check("alt_count", 64'(grant_log.size()), 64'(4));
    for (int i = 0; i < grant_log.size() && i < 4; i++) check("alt_order", 64'(grant_log[i]), 64'(i % 2));
    wait_idle();

    // Single normalized request through the divider
    set_req(0, 32'hC000_0000, 32'h8000_0000, 4'd3);
    wait_accept(0);
    wait_idle();

    // Unnormalized divisor bypasses the divider
    set_req(1, 32'h8000_0000, 32'h4000_0000, 4'd5);
    wait_accept(1);
    wait_idle();

    // Back-pressure on rsp0 while req1 waits
    bus.rsp0_ready = 1'b0;
    set_req(0, 32'hE000_0000, 32'h9000_0000, 4'd7);
    wait_accept(0);
    set_req(1, 32'h9000_0000, 32'hF000_0000, 4'd9);
    repeat (16) @(posedge clock);
    #1;
    bus.rsp0_ready = 1'b1;
    wait_accept(1);
    wait_idle();

    // Watchdog: divider hangs, grants withheld while it stays busy
    hang = 1'b1;
    set_req(0, 32'hB000_0000, 32'hA000_0000, 4'd4);
    wait_accept(0);
    @(posedge clock); #1;
    hang = 1'b0;
    set_req(1, 32'hC800_0000, 32'h8800_0000, 4'd6);
    wait_accept(1);
    wait_idle();

    // Stray ready pulse while idle must not produce a response
    @(posedge clock); #1 spur = 1'b1;
    @(posedge clock); #1 spur = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    check("spurious_no_rsp", 64'({bus.rsp0_valid, bus.rsp1_valid}), 64'(0));

    // Reset during WAIT clears outputs at once; requester 0 has priority afterwards
    set_req(1, 32'h8000_0000, 32'h8000_0000, 4'd11);
    set_req(0, 32'hF000_0000, 32'h8000_0000, 4'd10);
    bus.req1_valid = 1'b0;
    wait_accept(0);
    set_req(0, 32'hD000_0000, 32'h8000_0000, 4'd12);
    set_req(1, 32'h8000_0000, 32'h8000_0000, 4'd11);
    @(posedge clock);
    #3 reset = 1'b1;
    #1;
    check("rst_ctrl_outputs", 64'({bus.req0_ready, bus.req1_ready, bus.rsp0_valid, bus.rsp1_valid,
                                   bus.rsp0_err, bus.rsp1_err, bus.div_start}), 64'(0));
    check("rst_data_outputs", 64'(bus.div_a | bus.div_b | bus.rsp0_q | bus.rsp1_q), 64'(0));
    check("rst_tag_outputs", 64'({bus.rsp0_tag, bus.rsp1_tag}), 64'(0));
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
    grant_log.delete();
    log_on = 1'b1;
    for (int i = 0; i < 20 && grant_log.size() < 1; i++) begin @(posedge clock); #1; end
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    log_on = 1'b0;
    check("post_reset_grants", 64'(grant_log.size()), 64'(1));
    if (grant_log.size() > 0) check("post_reset_first", 64'(grant_log[0]), 64'(0));
    wait_idle();

    // Random traffic with random response back-pressure
    for (int i = 0; i < 800; i++) begin
      @(negedge clock);
      a0 = bus.req0_valid && bus.req0_ready;
      a1 = bus.req1_valid && bus.req1_ready;
      @(posedge clock); #1;
      if (a0 || !bus.req0_valid) begin
        if ($urandom_range(0, 3) != 0) rand_req(0); else bus.req0_valid = 1'b0;
      end else if ($urandom_range(0, 19) == 0) bus.req0_valid = 1'b0;
      if (a1 || !bus.req1_valid) begin
        if ($urandom_range(0, 3) != 0) rand_req(1); else bus.req1_valid = 1'b0;
      end else if ($urandom_range(0, 19) == 0) bus.req1_valid = 1'b0;
      bus.rsp0_ready = ($urandom_range(0, 3) != 0);
      bus.rsp1_ready = ($urandom_range(0, 3) != 0);
    end
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
    bus.rsp0_ready = 1'b1; bus.rsp1_ready = 1'b1;
    wait_idle();

    $display("CHECKS %0d ERRORS %0d", chk, errs);
    $finish;
  end

endmodule

// File: doc/fdiv_share_ctrl.md
Name: fdiv_share_ctrl

Overview:
Controller that shares one 32-bit iterative fraction divider (3-iteration Newton, one-cycle start, one-cycle ready pulse) between two requesters.
- Arbitrates round-robin, accepts one operation at a time, sequences the divider's start/operand interface and captures its quotient.
- Returns the result with the requester's tag over a valid/ready response channel.
- Guards against unnormalized divisors and against a divider that never signals ready (watchdog).
- Sits between the FP divide/sqrt issue ports and the shared fraction divider in the FPU.

Parameters:
TAG_W, 4, width of the per-request tag echoed on the response.
TIMEOUT, 15, WAIT-state cycles without div_ready before an error response; must be greater than 5.

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high reset
req0_valid  in  1  requester 0 has an operation
req0_ready  out  1  requester 0 operation accepted this cycle
req0_a  in  32  dividend fraction, .1xxx…x
req0_b  in  32  divisor fraction, .1xxx…x
req0_tag  in  TAG_W  requester 0 tag
req1_valid, req1_ready, req1_a, req1_b, req1_tag  same as requester 0
rsp0_valid  out  1  response for requester 0 valid
rsp0_ready  in  1  requester 0 takes the response
rsp0_q  out  32  quotient, x.xxx…x
rsp0_tag  out  TAG_W  echoed tag
rsp0_err  out  1  unnormalized divisor or timeout
rsp1_valid, rsp1_ready, rsp1_q, rsp1_tag, rsp1_err  same as response 0
div_start  out  1  one-cycle start to the divider
div_a  out  32  dividend to the divider
div_b  out  32  divisor to the divider
div_busy  in  1  divider busy
div_ready  in  1  one-cycle result-ready pulse
div_q  in  32  divider quotient

Behaviour:
- Reset (asynchronous, immediate, mid-operation included):
  - state = IDLE.
  - All outputs 0; div_start drops at once.
  - Operand, result and tag registers = 0.
  - last_grant = 1, so requester 0 wins first.
- FSM states: IDLE, START, WAIT, RESP.
- IDLE:
  - If div_busy = 1, grant nothing (stale op after a timeout).
  - Otherwise grant the single valid requester. If both are valid, grant the one that is not last_grant.
  - reqX_ready = 1 combinationally, for the granted requester only; at most one req_ready high per cycle.
  - On acceptance, latch a, b, tag and owner.
  - If latched b[31] = 1, go to START. If b[31] = 0, set err = 1, q = 0 and go to RESP, bypassing the divider.
- START: div_start = 1 for exactly this cycle; clear the watchdog; go to WAIT.
- div_a and div_b continuously drive the latched operands (held through WAIT and RESP).
- WAIT:
  - Watchdog counts cycles.
  - div_ready = 1: capture div_q, err = 0, go to RESP.
  - Watchdog = TIMEOUT with no ready: q = 0, err = 1, go to RESP.
  - If div_ready and timeout coincide, div_ready wins.
- RESP:
  - rspX_valid = 1 for the owner only; q, tag and err stay stable until rspX_ready = 1.
  - On the handshake: last_grant = owner, go to IDLE.
  - No new acceptance while in RESP; there is no IDLE bypass.
- Latency with the 3-iteration divider, acceptance in cycle C0:
  - div_start in C1.
  - div_ready in C5.
  - rsp_valid in C6.
  - Next acceptance no earlier than C7, with rsp_ready = 1 in C6.
- Error path: rsp_valid in C1.
- A requester may drop valid before being granted; nothing is accepted or lost.
- A div_ready outside WAIT is ignored.
- Throughput: one operation in flight; requesters see back-pressure through req_ready.

Decomposition:
- Package fdiv_share_pkg: FSM state encoding (2-bit IDLE/START/WAIT/RESP), DIV_W = 32, default TAG_W, default TIMEOUT, watchdog width (4 bits at default).
- One sub-module, rr_arb2: two-request round-robin grant, combinational from valid[1:0] and last_grant.
- FSM, operand/result registers and watchdog live in the top.

Test Plan:
- Single request: req0 a = 0xC0000000, b = 0x80000000, tag = 3, real divider → rsp0_valid in C6, q = 0xC0000000 ±1 LSB, tag = 3, err = 0; div_start high exactly one cycle.
- Both requesters valid at reset release, tags 1 and 2, rsp_ready held at 1 → req0 served first, then req1; with both held valid, grants alternate 0,1,0,1 over 4 ops.
- Unnormalized divisor: req1 b = 0x40000000 → no div_start, rsp1_valid in C1 with err = 1, q = 0.
- Back-pressure: rsp0_ready held at 0 for 10 cycles while req1_valid = 1 → rsp0 q/tag stable, req1_ready stays 0; req1 accepted the cycle after the rsp0 handshake returns to IDLE.
- Watchdog: stub divider never pulses ready → err response exactly TIMEOUT cycles into WAIT; a new grant is withheld while stub div_busy = 1.
- Reset asserted in WAIT → all outputs 0 in the same cycle; after release, requester 0 has priority.
